// File: rtl/mc_controller_v2.sv
// Multicycle MIPS-subset control unit with memory-ready stalls and a retired-instruction counter.
// Define CU_ILLEGAL_TRAP_EN to route undefined opcodes through a one-cycle TRAP state.
module mc_controller_v2 #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               memread_o,
    output logic               memwrite_o,
    output logic               mem_byte_o,
    output logic               iord_o,
    output logic               irwrite_o,
    output logic               alusrca_o,
    output logic [2:0]         alusrcb_o,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic [1:0]         pcsource_o,
    output logic               pcen_o,
    output logic               regwrite_o,
    output logic [1:0]         regdst_o,
    output logic               memtoreg_o,
    output logic               link_o,
    output logic               trap_o,
    output logic [CNT_W-1:0]   instret_o
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(4);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPE_EX,
        S_IMM_EX,
        S_ALU_WB,
        S_BRANCH,
`ifdef CU_ILLEGAL_TRAP_EN
        S_TRAP,
`endif
        S_JUMP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] instret_reg;
    logic             retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire)
                instret_reg <= instret_reg + 1'b1;
        end
    end

    assign instret_o = instret_reg;

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        memread_o  = 1'b0;
        memwrite_o = 1'b0;
        mem_byte_o = 1'b0;
        iord_o     = 1'b0;
        irwrite_o  = 1'b0;
        alusrca_o  = 1'b0;
        alusrcb_o  = 3'b000;
        aluop_o    = ALU_ADD;
        pcsource_o = 2'b00;
        pcen_o     = 1'b0;
        regwrite_o = 1'b0;
        regdst_o   = 2'b00;
        memtoreg_o = 1'b0;
        link_o     = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
        trap_o     = 1'b0;
`endif

        case (state_reg)
            S_FETCH: begin
                memread_o = 1'b1;
                alusrcb_o = 3'b001;
                aluop_o   = ALU_ADD;
                if (mem_ready_i) begin
                    irwrite_o  = 1'b1;
                    pcen_o     = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is examined.
                alusrcb_o = 3'b011;
                case (op_i)
                    OP_LB, OP_LW, OP_SB, OP_SW:  state_next = S_MEMADR;
                    OP_R:                        state_next = S_RTYPE_EX;
                    OP_ADDI, OP_ANDI, OP_ORI:    state_next = S_IMM_EX;
                    OP_BEQ, OP_BNE:              state_next = S_BRANCH;
                    OP_J, OP_JAL:                state_next = S_JUMP;
`ifdef CU_ILLEGAL_TRAP_EN
                    default:                     state_next = S_TRAP;
`else
                    default:                     state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alusrca_o  = 1'b1;
                alusrcb_o  = 3'b010;
                state_next = (op_i == OP_SB || op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread_o  = 1'b1;
                iord_o     = 1'b1;
                mem_byte_o = (op_i == OP_LB);
                if (mem_ready_i)
                    state_next = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite_o = 1'b1;
                memtoreg_o = 1'b1;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                // Write request is held for the whole stall; retire only once accepted.
                memwrite_o = 1'b1;
                iord_o     = 1'b1;
                mem_byte_o = (op_i == OP_SB);
                if (mem_ready_i) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_RTYPE_EX: begin
                alusrca_o  = 1'b1;
                aluop_o    = ALU_FUNCT;
                state_next = S_ALU_WB;
            end
            S_IMM_EX: begin
                alusrca_o  = 1'b1;
                state_next = S_ALU_WB;
                case (op_i)
                    OP_ANDI: begin
                        alusrcb_o = 3'b100;
                        aluop_o   = ALU_AND;
                    end
                    OP_ORI: begin
                        alusrcb_o = 3'b100;
                        aluop_o   = ALU_OR;
                    end
                    default: begin
                        alusrcb_o = 3'b010;
                        aluop_o   = ALU_ADD;
                    end
                endcase
            end
            S_ALU_WB: begin
                regwrite_o = 1'b1;
                regdst_o   = (op_i == OP_R) ? 2'b01 : 2'b00;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                alusrca_o  = 1'b1;
                aluop_o    = ALU_SUB;
                pcsource_o = 2'b01;
                pcen_o     = (op_i == OP_BNE) ? ~zero_i : zero_i;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_JUMP: begin
                pcsource_o = 2'b10;
                pcen_o     = 1'b1;
                if (op_i == OP_JAL) begin
                    regwrite_o = 1'b1;
                    regdst_o   = 2'b10;
                    link_o     = 1'b1;
                end
                state_next = S_FETCH;
                retire     = 1'b1;
            end
`ifdef CU_ILLEGAL_TRAP_EN
            S_TRAP: begin
                trap_o     = 1'b1;
                pcsource_o = 2'b11;
                pcen_o     = 1'b1;
                state_next = S_FETCH;
            end
`endif
            default: state_next = S_FETCH;
        endcase

        // Reset masks every control so an in-flight access never writes.
        if (rst) begin
            memread_o  = 1'b0;
            memwrite_o = 1'b0;
            mem_byte_o = 1'b0;
            iord_o     = 1'b0;
            irwrite_o  = 1'b0;
            alusrca_o  = 1'b0;
            alusrcb_o  = 3'b000;
            aluop_o    = '0;
            pcsource_o = 2'b00;
            pcen_o     = 1'b0;
            regwrite_o = 1'b0;
            regdst_o   = 2'b00;
            memtoreg_o = 1'b0;
            link_o     = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
            trap_o     = 1'b0;
`endif
        end
    end

`ifndef CU_ILLEGAL_TRAP_EN
    assign trap_o = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller_v2.sv
// Directed, table-driven bench for mc_controller_v2 (CNT_W = 4 so counter wrap is reachable).
// Expectations follow the CU_ILLEGAL_TRAP_EN setting of the build.
module tb_mc_controller_v2;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op_i = '0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       memread_o, memwrite_o, mem_byte_o, iord_o, irwrite_o, alusrca_o;
    logic [2:0] alusrcb_o, aluop_o;
    logic [1:0] pcsource_o, regdst_o;
    logic       pcen_o, regwrite_o, memtoreg_o, link_o, trap_o;
    logic [3:0] instret_o;

    always #5 clk = ~clk;

    mc_controller_v2 #(.ALUOP_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .op_i(op_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .memread_o(memread_o), .memwrite_o(memwrite_o), .mem_byte_o(mem_byte_o),
        .iord_o(iord_o), .irwrite_o(irwrite_o), .alusrca_o(alusrca_o),
        .alusrcb_o(alusrcb_o), .aluop_o(aluop_o), .pcsource_o(pcsource_o),
        .pcen_o(pcen_o), .regwrite_o(regwrite_o), .regdst_o(regdst_o),
        .memtoreg_o(memtoreg_o), .link_o(link_o), .trap_o(trap_o), .instret_o(instret_o)
    );

    // Packed view: {mr,mw,mb,iord,irw,asa,asb[3],aop[3],pcs[2],pcen,rw,rd[2],mtr,link,trap}
    logic [20:0] got_ctrl;
    assign got_ctrl = {memread_o, memwrite_o, mem_byte_o, iord_o, irwrite_o, alusrca_o,
                       alusrcb_o, aluop_o, pcsource_o, pcen_o, regwrite_o, regdst_o,
                       memtoreg_o, link_o, trap_o};

    function automatic logic [20:0] mk(input logic mr, input logic mw, input logic mb,
                                       input logic io, input logic irw, input logic asa,
                                       input logic [2:0] asb, input logic [2:0] aop,
                                       input logic [1:0] pcs, input logic pce, input logic rw,
                                       input logic [1:0] rd, input logic mtr,
                                       input logic lnk, input logic trp);
        return {mr, mw, mb, io, irw, asa, asb, aop, pcs, pce, rw, rd, mtr, lnk, trp};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        ready;
        logic [20:0] exp;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   idx = 0;

    logic [20:0] Z, F0, F1, DEC, MADR, MRDW, MRDB, MWB, MWRW, MWRB, REX;
    logic [20:0] IADD, IAND, IOR, AWBR, AWBI, BR0, BR1, JMP, JAL, TRP;

    task automatic add(input logic r, input logic [5:0] o, input logic z, input logic rdy,
                       input logic [20:0] e, input logic [3:0] c);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.ready = rdy; v.exp = e; v.cnt = c;
        vq.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        rst = v.rst; op_i = v.op; zero_i = v.zero; mem_ready_i = v.ready;
        #1;
        $display("vec %0d rst=%0b op=%b zero=%0b ready=%0b ctrl=%h instret=%0d",
                 idx, v.rst, v.op, v.zero, v.ready, got_ctrl, instret_o);
        checks++;
        if (got_ctrl !== v.exp) begin
            errors++;
            $display("FAIL ctrl vec %0d: got %b expected %b", idx, got_ctrl, v.exp);
        end
        checks++;
        if (instret_o !== v.cnt) begin
            errors++;
            $display("FAIL instret vec %0d: got %0d expected %0d", idx, instret_o, v.cnt);
        end
        idx++;
    endtask

    initial begin
        Z    = '0;
        F0   = mk(1,0,0,0,0,0,3'b001,3'd0,2'b00,0,0,2'b00,0,0,0);
        F1   = mk(1,0,0,0,1,0,3'b001,3'd0,2'b00,1,0,2'b00,0,0,0);
        DEC  = mk(0,0,0,0,0,0,3'b011,3'd0,2'b00,0,0,2'b00,0,0,0);
        MADR = mk(0,0,0,0,0,1,3'b010,3'd0,2'b00,0,0,2'b00,0,0,0);
        MRDW = mk(1,0,0,1,0,0,3'b000,3'd0,2'b00,0,0,2'b00,0,0,0);
        MRDB = mk(1,0,1,1,0,0,3'b000,3'd0,2'b00,0,0,2'b00,0,0,0);
        MWB  = mk(0,0,0,0,0,0,3'b000,3'd0,2'b00,0,1,2'b00,1,0,0);
        MWRW = mk(0,1,0,1,0,0,3'b000,3'd0,2'b00,0,0,2'b00,0,0,0);
        MWRB = mk(0,1,1,1,0,0,3'b000,3'd0,2'b00,0,0,2'b00,0,0,0);
        REX  = mk(0,0,0,0,0,1,3'b000,3'd2,2'b00,0,0,2'b00,0,0,0);
        IADD = mk(0,0,0,0,0,1,3'b010,3'd0,2'b00,0,0,2'b00,0,0,0);
        IAND = mk(0,0,0,0,0,1,3'b100,3'd3,2'b00,0,0,2'b00,0,0,0);
        IOR  = mk(0,0,0,0,0,1,3'b100,3'd4,2'b00,0,0,2'b00,0,0,0);
        AWBR = mk(0,0,0,0,0,0,3'b000,3'd0,2'b00,0,1,2'b01,0,0,0);
        AWBI = mk(0,0,0,0,0,0,3'b000,3'd0,2'b00,0,1,2'b00,0,0,0);
        BR0  = mk(0,0,0,0,0,1,3'b000,3'd1,2'b01,0,0,2'b00,0,0,0);
        BR1  = mk(0,0,0,0,0,1,3'b000,3'd1,2'b01,1,0,2'b00,0,0,0);
        JMP  = mk(0,0,0,0,0,0,3'b000,3'd0,2'b10,1,0,2'b00,0,0,0);
        JAL  = mk(0,0,0,0,0,0,3'b000,3'd0,2'b10,1,1,2'b10,0,1,0);
        TRP  = mk(0,0,0,0,0,0,3'b000,3'd0,2'b11,1,0,2'b00,0,0,1);

        // Reset, then fetch stall of 3 cycles
        add(1, OP_LW, 0, 1, Z, 0);
        add(0, OP_LW, 0, 0, F0, 0);
        add(0, OP_LW, 0, 0, F0, 0);
        add(0, OP_LW, 0, 0, F0, 0);
        add(0, OP_LW, 0, 1, F1, 0);
        // LW with 2 stall cycles
        add(0, OP_LW, 0, 1, DEC, 0);
        add(0, OP_LW, 0, 1, MADR, 0);
        add(0, OP_LW, 0, 0, MRDW, 0);
        add(0, OP_LW, 0, 0, MRDW, 0);
        add(0, OP_LW, 0, 1, MRDW, 0);
        add(0, OP_LW, 0, 1, MWB, 0);
        // SB, ready immediately
        add(0, OP_SB, 0, 1, F1, 1);
        add(0, OP_SB, 0, 1, DEC, 1);
        add(0, OP_SB, 0, 1, MADR, 1);
        add(0, OP_SB, 0, 1, MWRB, 1);
        // Branches
        add(0, OP_BEQ, 1, 1, F1, 2);
        add(0, OP_BEQ, 1, 1, DEC, 2);
        add(0, OP_BEQ, 1, 1, BR1, 2);
        add(0, OP_BNE, 1, 1, F1, 3);
        add(0, OP_BNE, 1, 1, DEC, 3);
        add(0, OP_BNE, 1, 1, BR0, 3);
        add(0, OP_BNE, 0, 1, F1, 4);
        add(0, OP_BNE, 0, 1, DEC, 4);
        add(0, OP_BNE, 0, 1, BR1, 4);
        // JAL, ORI, R, ANDI, ADDI, J
        add(0, OP_JAL, 0, 1, F1, 5);
        add(0, OP_JAL, 0, 1, DEC, 5);
        add(0, OP_JAL, 0, 1, JAL, 5);
        add(0, OP_ORI, 0, 1, F1, 6);
        add(0, OP_ORI, 0, 1, DEC, 6);
        add(0, OP_ORI, 0, 1, IOR, 6);
        add(0, OP_ORI, 0, 1, AWBI, 6);
        add(0, OP_R, 0, 1, F1, 7);
        add(0, OP_R, 0, 1, DEC, 7);
        add(0, OP_R, 0, 1, REX, 7);
        add(0, OP_R, 0, 1, AWBR, 7);
        add(0, OP_ANDI, 0, 1, F1, 8);
        add(0, OP_ANDI, 0, 1, DEC, 8);
        add(0, OP_ANDI, 0, 1, IAND, 8);
        add(0, OP_ANDI, 0, 1, AWBI, 8);
        add(0, OP_ADDI, 0, 1, F1, 9);
        add(0, OP_ADDI, 0, 1, DEC, 9);
        add(0, OP_ADDI, 0, 1, IADD, 9);
        add(0, OP_ADDI, 0, 1, AWBI, 9);
        add(0, OP_J, 0, 1, F1, 10);
        add(0, OP_J, 0, 1, DEC, 10);
        add(0, OP_J, 0, 1, JMP, 10);
        // Illegal opcode: no retire either way
        add(0, OP_BAD, 0, 1, F1, 11);
        add(0, OP_BAD, 0, 1, DEC, 11);
`ifdef CU_ILLEGAL_TRAP_EN
        add(0, OP_BAD, 0, 1, TRP, 11);
`endif
        add(0, OP_SW, 0, 1, F1, 11);
        add(0, OP_SW, 0, 1, DEC, 11);
        add(0, OP_SW, 0, 1, MADR, 11);
        add(0, OP_SW, 0, 1, MWRW, 11);
        add(0, OP_LB, 0, 1, F1, 12);
        add(0, OP_LB, 0, 1, DEC, 12);
        add(0, OP_LB, 0, 1, MADR, 12);
        add(0, OP_LB, 0, 1, MRDB, 12);
        add(0, OP_LB, 0, 1, MWB, 12);
        // Three jumps take the counter 13 -> 15 -> wrap to 0
        add(0, OP_J, 0, 1, F1, 13);
        add(0, OP_J, 0, 1, DEC, 13);
        add(0, OP_J, 0, 1, JMP, 13);
        add(0, OP_J, 0, 1, F1, 14);
        add(0, OP_J, 0, 1, DEC, 14);
        add(0, OP_J, 0, 1, JMP, 14);
        add(0, OP_J, 0, 1, F1, 15);
        add(0, OP_J, 0, 1, DEC, 15);
        add(0, OP_J, 0, 1, JMP, 15);
        add(0, OP_J, 0, 1, F1, 0);
        add(0, OP_J, 0, 1, DEC, 0);
        add(0, OP_J, 0, 1, JMP, 0);

        // Initial reset: two edges with rst high
        @(posedge clk);
        @(posedge clk);

        for (int i = 0; i < vq.size(); i++)
            run_vec(vq[i]);

        // Reset while a stalled SW write is in flight
        begin
            vec_t seq[$];
            vec_t v;
            v.zero = 0;
            v.op = OP_SW;
            v.rst = 0; v.ready = 1; v.exp = F1;   v.cnt = 1; seq.push_back(v);
            v.rst = 0; v.ready = 1; v.exp = DEC;  v.cnt = 1; seq.push_back(v);
            v.rst = 0; v.ready = 1; v.exp = MADR; v.cnt = 1; seq.push_back(v);
            v.rst = 0; v.ready = 0; v.exp = MWRW; v.cnt = 1; seq.push_back(v);
            v.rst = 0; v.ready = 0; v.exp = MWRW; v.cnt = 1; seq.push_back(v);
            v.rst = 1; v.ready = 0; v.exp = Z;    v.cnt = 1; seq.push_back(v);
            v.rst = 1; v.ready = 1; v.exp = Z;    v.cnt = 0; seq.push_back(v);
            v.rst = 0; v.ready = 0; v.exp = F0;   v.cnt = 0; seq.push_back(v);
            v.rst = 0; v.ready = 0; v.exp = F0;   v.cnt = 0; seq.push_back(v);
            v.rst = 0; v.ready = 1; v.exp = F1;   v.cnt = 0; seq.push_back(v);
            for (int i = 0; i < seq.size(); i++)
                run_vec(seq[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog keeps the run bounded even if the stimulus stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
